// File: rtl/mpu_multi_sensor_reader_if.sv
// Byte-level SPI transaction port shared by the MPU reader and its SPI engine.
//   spi_address   register address for the transaction
//   spi_wr_data   byte to write
//   spi_rd_wr_sel 1 = read, 0 = write
//   spi_start     one-cycle transaction request
//   spi_busy      transaction in progress
//   spi_rd_data   byte returned by the last read
interface mpu_multi_sensor_reader_if;
    logic [6:0] spi_address;
    logic [7:0] spi_wr_data;
    logic       spi_rd_wr_sel;
    logic       spi_start;
    logic       spi_busy;
    logic [7:0] spi_rd_data;

    modport master (
        output spi_address, spi_wr_data, spi_rd_wr_sel, spi_start,
        input  spi_busy, spi_rd_data
    );

    modport slave (
        input  spi_address, spi_wr_data, spi_rd_wr_sel, spi_start,
        output spi_busy, spi_rd_data
    );
endinterface

// File: rtl/mpu_multi_sensor_reader.sv
// MPU9250 multi-channel poller: runs the init sequence, checks WHO_AM_I, then
// periodically burst-reads NUM_CH big-endian 16-bit registers from BASE_ADDR
// and publishes each complete frame atomically.
// Optional: define MPU_DRDY_POLL_EN to poll INT_STATUS (0x3A) bit0 before
// every burst.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   spi              byte-level SPI transaction port (master side)
//   sensor_data      channel k at [16k+15:16k] as {high, low}
//   frame_valid      one-cycle pulse when sensor_data updates
//   frame_count      completed frames, wraps
//   arm_read_enable  ARM side may sample sensor_data
//   whoami           captured WHO_AM_I byte
//   id_error         sticky WHO_AM_I mismatch
module mpu_multi_sensor_reader #(
    parameter int unsigned NUM_CH      = 3,
    parameter logic [6:0]  BASE_ADDR   = 7'h3B,
    parameter logic [7:0]  EXPECT_ID   = 8'h71,
    parameter int unsigned IDLE_CYCLES = 1000000,
    parameter int unsigned READY_LEAD  = 1000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mpu_multi_sensor_reader_if.master    spi,
    output logic [16*NUM_CH-1:0]         sensor_data,
    output logic                         frame_valid,
    output logic [15:0]                  frame_count,
    output logic                         arm_read_enable,
    output logic [7:0]                   whoami,
    output logic                         id_error
);
    localparam int unsigned DW     = 16 * NUM_CH;
    localparam int unsigned NBYTES = 2 * NUM_CH;
    localparam int unsigned CNT_W  = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_WR_PWR = 4'd1;
    localparam logic [3:0] ST_RD_ID  = 4'd2;
    localparam logic [3:0] ST_WR_BYP = 4'd3;
    localparam logic [3:0] ST_FRAME  = 4'd4;
    localparam logic [3:0] ST_COMMIT = 4'd5;
    localparam logic [3:0] ST_IDLE   = 4'd6;
    localparam logic [3:0] ST_FAULT  = 4'd7;
`ifdef MPU_DRDY_POLL_EN
    localparam logic [3:0] ST_POLL      = 4'd8;
    localparam logic [3:0] ST_PRE_FRAME = ST_POLL;
`else
    localparam logic [3:0] ST_PRE_FRAME = ST_FRAME;
`endif

    localparam logic [1:0] PH_ISSUE = 2'd0;
    localparam logic [1:0] PH_ACK   = 2'd1;
    localparam logic [1:0] PH_DONE  = 2'd2;

    // Reject parameter sets whose burst would wrap the 7-bit address space.
    generate
        if (NUM_CH < 1 || NUM_CH > 7 || 32'(BASE_ADDR) + 2 * NUM_CH - 1 > 127 ||
            IDLE_CYCLES < READY_LEAD + 2) begin : g_bad_param
            $error("mpu_multi_sensor_reader: illegal parameter combination");
        end
    endgenerate

    logic [3:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       byte_q, byte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]    sensor_q, sensor_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             sel_q, sel_d;
    logic             start_q, start_d;
    logic             fv_q, fv_d;
    logic [15:0]      fcount_q, fcount_d;
    logic             arm_q, arm_d;
    logic [7:0]       whoami_q, whoami_d;
    logic             id_err_q, id_err_d;

    logic             txn_en;
    logic [6:0]       txn_addr;
    logic [7:0]       txn_wdata;
    logic             txn_rd;
    logic             txn_done;

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            phase_q  <= PH_ISSUE;
            byte_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            sensor_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b1;
            start_q  <= 1'b0;
            fv_q     <= 1'b0;
            fcount_q <= '0;
            arm_q    <= 1'b0;
            whoami_q <= '0;
            id_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sensor_q <= sensor_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            fv_q     <= fv_d;
            fcount_q <= fcount_d;
            arm_q    <= arm_d;
            whoami_q <= whoami_d;
            id_err_q <= id_err_d;
        end
    end

    // Next-state: per-state transaction selection, shared handshake, then sequencing.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        sensor_d  = sensor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        fv_d      = 1'b0;
        fcount_d  = fcount_q;
        arm_d     = arm_q;
        whoami_d  = whoami_q;
        id_err_d  = id_err_q;
        txn_en    = 1'b0;
        txn_addr  = 7'h00;
        txn_wdata = 8'h00;
        txn_rd    = 1'b1;
        txn_done  = 1'b0;

        case (state_q)
            ST_WR_PWR: begin txn_en = 1'b1; txn_addr = 7'h6B; txn_wdata = 8'h00; txn_rd = 1'b0; end
            ST_RD_ID:  begin txn_en = 1'b1; txn_addr = 7'h75; end
            ST_WR_BYP: begin txn_en = 1'b1; txn_addr = 7'h37; txn_wdata = 8'h02; txn_rd = 1'b0; end
`ifdef MPU_DRDY_POLL_EN
            ST_POLL:   begin txn_en = 1'b1; txn_addr = 7'h3A; end
`endif
            ST_FRAME:  begin txn_en = 1'b1; txn_addr = BASE_ADDR + 7'(byte_q); end
            default: ;
        endcase

        // Address/data/sel are only loaded at issue, so they stay stable until done.
        if (txn_en) begin
            case (phase_q)
                PH_ISSUE: if (!spi.spi_busy) begin
                    addr_d  = txn_addr;
                    wdata_d = txn_wdata;
                    sel_d   = txn_rd;
                    start_d = 1'b1;
                    phase_d = PH_ACK;
                end
                PH_ACK:   if (spi.spi_busy) phase_d = PH_DONE;
                PH_DONE:  if (!spi.spi_busy) begin
                    txn_done = 1'b1;
                    phase_d  = PH_ISSUE;
                end
                default:  phase_d = PH_ISSUE;
            endcase
        end

        case (state_q)
            ST_INIT:   if (!spi.spi_busy) state_d = ST_WR_PWR;
            ST_WR_PWR: if (txn_done) state_d = ST_RD_ID;
            ST_RD_ID:  if (txn_done) begin
                whoami_d = spi.spi_rd_data;
                if (spi.spi_rd_data != EXPECT_ID) begin
                    id_err_d = 1'b1;
                    state_d  = ST_FAULT;
                end else begin
                    state_d = ST_WR_BYP;
                end
            end
            ST_WR_BYP: if (txn_done) state_d = ST_PRE_FRAME;
`ifdef MPU_DRDY_POLL_EN
            ST_POLL:   if (txn_done && spi.spi_rd_data[0]) state_d = ST_FRAME;
`endif
            ST_FRAME: begin
                if (phase_q == PH_ISSUE && !spi.spi_busy && byte_q == 4'd0) arm_d = 1'b0;
                if (txn_done) begin
                    // Even byte is the channel high byte, odd byte the low byte.
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (byte_q[3:1] == 3'(k)) begin
                            if (byte_q[0]) shadow_d[16*k +: 8]     = spi.spi_rd_data;
                            else           shadow_d[16*k + 8 +: 8] = spi.spi_rd_data;
                        end
                    end
                    if (byte_q == 4'(NBYTES - 1)) begin
                        byte_d  = 4'd0;
                        state_d = ST_COMMIT;
                    end else begin
                        byte_d = byte_q + 4'd1;
                    end
                end
            end
            ST_COMMIT: begin
                sensor_d = shadow_q;
                fv_d     = 1'b1;
                fcount_d = fcount_q + 16'd1;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (cnt_q == CNT_W'(IDLE_CYCLES - READY_LEAD)) arm_d = 1'b1;
                if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) state_d = ST_PRE_FRAME;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_FAULT: ;
            default:  state_d = ST_INIT;
        endcase
    end

    assign spi.spi_address   = addr_q;
    assign spi.spi_wr_data   = wdata_q;
    assign spi.spi_rd_wr_sel = sel_q;
    assign spi.spi_start     = start_q;
    assign sensor_data       = sensor_q;
    assign frame_valid       = fv_q;
    assign frame_count       = fcount_q;
    assign arm_read_enable   = arm_q;
    assign whoami            = whoami_q;
    assign id_error          = id_err_q;
endmodule

// File: tb/tb_mpu_multi_sensor_reader.sv
// Directed bench for mpu_multi_sensor_reader with a behavioural SPI engine model.
module tb_mpu_multi_sensor_reader;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned IDLE   = 50;
    localparam int unsigned LEAD   = 10;
`ifdef MPU_DRDY_POLL_EN
    localparam int POLL_N = 4;
`else
    localparam int POLL_N = 0;
`endif
    // Each byte: issue, ack, three busy cycles seen by DONE.
    localparam int TXN_CYC = 5;
    localparam int PERIOD  = IDLE + 1 + (2 * NUM_CH + POLL_N) * TXN_CYC;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mpu_multi_sensor_reader_if spi_bus ();

    logic [47:0] sensor_data;
    logic        frame_valid;
    logic [15:0] frame_count;
    logic        arm_read_enable;
    logic [7:0]  whoami;
    logic        id_error;

    mpu_multi_sensor_reader #(
        .NUM_CH(NUM_CH), .BASE_ADDR(7'h3B), .EXPECT_ID(8'h71),
        .IDLE_CYCLES(IDLE), .READY_LEAD(LEAD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .spi(spi_bus),
        .sensor_data(sensor_data), .frame_valid(frame_valid),
        .frame_count(frame_count), .arm_read_enable(arm_read_enable),
        .whoami(whoami), .id_error(id_error)
    );

    int checks = 0;
    int failures = 0;

    // SPI engine model
    logic       model_busy = 1'b0;
    logic       busy_hold = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] pend = 8'h00;
    logic [7:0] id_val = 8'h71;
    logic [7:0] data_ofs = 8'h00;
    int         poll_cnt = 0;
    logic [6:0] log_addr [0:511];
    logic       log_rd [0:511];
    logic [7:0] log_wd [0:511];
    int         log_n = 0;

    assign spi_bus.spi_busy = model_busy | busy_hold;

    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                model_busy = 1'b0;
                spi_bus.spi_rd_data = pend;
            end
        end
        if (spi_bus.spi_start) begin
            if (log_n < 512) begin
                log_addr[log_n] = spi_bus.spi_address;
                log_rd[log_n]   = spi_bus.spi_rd_wr_sel;
                log_wd[log_n]   = spi_bus.spi_wr_data;
            end
            log_n = log_n + 1;
            case (spi_bus.spi_address)
                7'h75: pend = id_val;
                7'h3A: begin
                    pend = (poll_cnt == 3) ? 8'h01 : 8'h00;
                    poll_cnt = (poll_cnt == 3) ? 0 : poll_cnt + 1;
                end
                default: pend = {1'b0, spi_bus.spi_address} + data_ofs;
            endcase
            model_busy = 1'b1;
            busy_cnt = 3;
        end
    end

    // Monitors: published data may only move together with frame_valid.
    logic [47:0] prev_sd = '0;
    int bad_change = 0;
    int fv_count = 0;
    always @(negedge clk) begin
        if (reset_n && sensor_data !== prev_sd && !frame_valid) bad_change = bad_change + 1;
        if (frame_valid) fv_count = fv_count + 1;
        prev_sd = sensor_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (log_n >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fv(input int budget, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            cyc = cyc + 1;
            if (frame_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if ({spi_bus.spi_address, spi_bus.spi_wr_data, spi_bus.spi_start} !== 16'h0) begin
            failures++; $display("FAIL reset_spi: got %h required 0", {spi_bus.spi_address, spi_bus.spi_wr_data, spi_bus.spi_start}); end
        checks++; if (spi_bus.spi_rd_wr_sel !== 1'b1) begin
            failures++; $display("FAIL reset_sel: got %b required 1", spi_bus.spi_rd_wr_sel); end
        checks++; if (sensor_data !== 48'h0) begin
            failures++; $display("FAIL reset_sensor: got %h required 0", sensor_data); end
        checks++; if ({frame_valid, arm_read_enable, id_error} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b required 000", {frame_valid, arm_read_enable, id_error}); end
        checks++; if (frame_count !== 16'h0 || whoami !== 8'h0) begin
            failures++; $display("FAIL reset_count_id: got %h/%h required 0/0", frame_count, whoami); end
    endtask

    task automatic test_stall();
        busy_hold = 1'b1;
        reset_n = 1'b1;
        repeat (20) step();
        checks++; if (log_n !== 0) begin
            failures++; $display("FAIL stall_no_start: got %0d starts required 0", log_n); end
        busy_hold = 1'b0;
    endtask

    task automatic test_init();
        bit ok;
        wait_log(3, 200, ok);
        checks++; if (!ok) begin
            failures++; $display("FAIL init_timeout: got %0d txns required 3", log_n); end
        checks++; if ({log_rd[0], log_addr[0], log_wd[0]} !== {1'b0, 7'h6B, 8'h00}) begin
            failures++; $display("FAIL init_pwr: got %b %h %h required 0 6b 00", log_rd[0], log_addr[0], log_wd[0]); end
        checks++; if ({log_rd[1], log_addr[1]} !== {1'b1, 7'h75}) begin
            failures++; $display("FAIL init_id: got %b %h required 1 75", log_rd[1], log_addr[1]); end
        checks++; if ({log_rd[2], log_addr[2], log_wd[2]} !== {1'b0, 7'h37, 8'h02}) begin
            failures++; $display("FAIL init_byp: got %b %h %h required 0 37 02", log_rd[2], log_addr[2], log_wd[2]); end
        checks++; if (whoami !== 8'h71 || id_error !== 1'b0) begin
            failures++; $display("FAIL init_whoami: got %h/%b required 71/0", whoami, id_error); end
    endtask

    task automatic test_frame();
        bit ok;
        int cyc;
        int n3a;
        wait_fv(500, ok, cyc);
        checks++; if (!ok) begin
            failures++; $display("FAIL frame_timeout: no frame_valid after %0d cycles", cyc); end
        for (int i = 0; i < 6; i++) begin
            logic [6:0] exp_a;
            exp_a = 7'(7'h3B + i);
            checks++; if ({log_rd[3+POLL_N+i], log_addr[3+POLL_N+i]} !== {1'b1, exp_a}) begin
                failures++; $display("FAIL frame_order[%0d]: got %b %h required 1 %h", i, log_rd[3+POLL_N+i], log_addr[3+POLL_N+i], exp_a); end
        end
        n3a = 0;
        for (int i = 0; i < log_n; i++) if (log_addr[i] == 7'h3A) n3a++;
        checks++; if (n3a != POLL_N) begin
            failures++; $display("FAIL frame_poll_reads: got %0d required %0d", n3a, POLL_N); end
        checks++; if (sensor_data !== 48'h3F40_3D3E_3B3C) begin
            failures++; $display("FAIL frame_data: got %h required 3f403d3e3b3c", sensor_data); end
        checks++; if (frame_count !== 16'd1) begin
            failures++; $display("FAIL frame_count1: got %0d required 1", frame_count); end
        step();
        checks++; if (frame_valid !== 1'b0 || fv_count != 1) begin
            failures++; $display("FAIL frame_pulse: got fv=%b pulses=%0d required 0/1", frame_valid, fv_count); end
    endtask

    task automatic test_arm_timing();
        bit ok;
        int cyc;
        bit fell;
        wait_fv(300, ok, cyc);
        checks++; if (!ok) begin
            failures++; $display("FAIL arm_fv_timeout: waited %0d cycles", cyc); end
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            cyc++;
            if (arm_read_enable) break;
        end
        checks++; if (cyc != int'(IDLE - LEAD + 1)) begin
            failures++; $display("FAIL arm_rise: got %0d cycles required %0d", cyc, IDLE - LEAD + 1); end
        fell = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!arm_read_enable) begin fell = 1'b1; break; end
        end
        checks++; if (!fell || spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== 7'h3B) begin
            failures++; $display("FAIL arm_fall: got fell=%b start=%b addr=%h required 1 1 3b", fell, spi_bus.spi_start, spi_bus.spi_address); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        wait_fv(300, ok, cyc);
        checks++; if (!ok) begin
            failures++; $display("FAIL b2b_timeout: waited %0d cycles", cyc); end
        for (int k = 0; k < 2; k++) begin
            wait_fv(300, ok, cyc);
            checks++; if (!ok || cyc != PERIOD) begin
                failures++; $display("FAIL b2b_period[%0d]: got %0d required %0d", k, cyc, PERIOD); end
        end
        checks++; if (frame_count !== 16'd5) begin
            failures++; $display("FAIL b2b_count: got %0d required 5", frame_count); end
    endtask

    task automatic test_mid_burst();
        bit ok;
        int cyc;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (spi_bus.spi_start && spi_bus.spi_address == 7'h3E) begin ok = 1'b1; break; end
        end
        data_ofs = 8'h10;
        checks++; if (!ok || sensor_data !== 48'h3F40_3D3E_3B3C) begin
            failures++; $display("FAIL mid_hold: got ok=%b data=%h required 1 3f403d3e3b3c", ok, sensor_data); end
        wait_fv(300, ok, cyc);
        data_ofs = 8'h00;
        checks++; if (!ok || sensor_data !== 48'h4F50_3D4E_3B3C) begin
            failures++; $display("FAIL mid_data: got %h required 4f503d4e3b3c", sensor_data); end
        checks++; if (bad_change != 0 || frame_count !== 16'd6) begin
            failures++; $display("FAIL mid_atomic: got changes=%0d count=%0d required 0/6", bad_change, frame_count); end
    endtask

    task automatic test_id_fault();
        int base;
        bit ok;
        reset_n = 1'b0;
        id_val = 8'h70;
        repeat (3) step();
        reset_n = 1'b1;
        base = log_n;
        repeat (400) step();
        checks++; if (id_error !== 1'b1 || whoami !== 8'h70) begin
            failures++; $display("FAIL fault_flag: got %b/%h required 1/70", id_error, whoami); end
        checks++; if (log_n - base != 2 || log_addr[base+1] !== 7'h75) begin
            failures++; $display("FAIL fault_quiet: got %0d txns required 2", log_n - base); end
        checks++; if (frame_count !== 16'd0 || sensor_data !== 48'h0) begin
            failures++; $display("FAIL fault_outputs: got %0d/%h required 0/0", frame_count, sensor_data); end
        reset_n = 1'b0;
        #1;
        checks++; if (id_error !== 1'b0) begin
            failures++; $display("FAIL fault_async_clear: got %b required 0", id_error); end
        id_val = 8'h71;
        repeat (2) step();
        reset_n = 1'b1;
        base = log_n;
        wait_log(base + 3, 200, ok);
        checks++; if (!ok || log_addr[base] !== 7'h6B || log_addr[base+2] !== 7'h37) begin
            failures++; $display("FAIL fault_restart: got ok=%b %h %h required 1 6b 37", ok, log_addr[base], log_addr[base+2]); end
        checks++; if (whoami !== 8'h71 || id_error !== 1'b0) begin
            failures++; $display("FAIL fault_reinit: got %h/%b required 71/0", whoami, id_error); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_init();
        test_frame();
        test_arm_timing();
        test_back_to_back();
        test_mid_burst();
        test_id_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
